// File: rtl/dmem_dma_pkg.sv
// -----------------------------------------------------------------------------
// dmem_dma_pkg
// Shared types and default widths for the data-memory DMA block.
//   DEF_AW / DEF_DW : default address / data widths (256 x 8 memory)
//   state_t         : transfer FSM states
//   mode_t          : transfer kind (COPY = memmove, FILL = constant byte)
// -----------------------------------------------------------------------------
package dmem_dma_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } mode_t;

endpackage

// File: rtl/dmem_dma_if.sv
// -----------------------------------------------------------------------------
// dmem_dma_if
// Bundles the DMA request/status signals and the data-memory port.
//   master : the DMA engine (takes requests, drives the memory port)
//   slave  : the environment (issues requests, provides the memory behind the port)
// Request : start, mode, src_addr, dst_addr, len, fill_val
// Status  : busy, done
// Memory  : mem_read, mem_write, mem_addr, mem_wdata, mem_rdata (1-cycle registered read)
// -----------------------------------------------------------------------------
interface dmem_dma_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] len;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    output busy, done, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    input  busy, done, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_dma_addr_gen.sv
// -----------------------------------------------------------------------------
// dmem_dma_addr_gen
// Holds the per-transfer bases, the byte offset, the remaining count and the
// direction flag. Emits the current source/destination addresses and a flag
// marking the last byte.
//   clk, rst_n   : clock, async active-low reset
//   i_load       : capture a new transfer (bases, length, direction)
//   i_step       : advance to the next byte (one per written byte)
//   i_copy       : transfer is a COPY (FILL always runs ascending)
//   i_src/i_dst  : base addresses
//   i_len        : byte count (non-zero when loaded)
//   o_src_addr   : src + offset (mod 2**AW)
//   o_dst_addr   : dst + offset (mod 2**AW)
//   o_last       : current byte is the final one
// -----------------------------------------------------------------------------
module dmem_dma_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic          i_copy,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [AW-1:0] i_len,
  output logic [AW-1:0] o_src_addr,
  output logic [AW-1:0] o_dst_addr,
  output logic          o_last
);

  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_off;
  logic [AW-1:0] r_rem;
  logic          r_desc;

  logic [AW-1:0] w_dist;
  logic          w_desc;

  // A destination that starts inside the source window (modular distance
  // 0 < d < len) would clobber unread source bytes going upward, so walk down.
  assign w_dist = i_dst - i_src;
  assign w_desc = i_copy && (w_dist != '0) && (w_dist < i_len);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_off  <= '0;
      r_rem  <= '0;
      r_desc <= 1'b0;
    end else if (i_load) begin
      r_src  <= i_src;
      r_dst  <= i_dst;
      r_rem  <= i_len;
      r_desc <= w_desc;
      r_off  <= w_desc ? (i_len - AW'(1)) : '0;
    end else if (i_step) begin
      r_off  <= r_desc ? (r_off - AW'(1)) : (r_off + AW'(1));
      r_rem  <= r_rem - AW'(1);
    end
  end

  assign o_src_addr = r_src + r_off;
  assign o_dst_addr = r_dst + r_off;
  assign o_last     = (r_rem == AW'(1));

endmodule

// File: rtl/dmem_dma.sv
// -----------------------------------------------------------------------------
// dmem_dma
// Data-memory DMA initiator: copies (memmove semantics) or fills a block of
// bytes through the shared 256x8 synchronous memory port while busy=1.
//   clk, rst_n : clock, async active-low reset
//   bus        : dmem_dma_if.master
//                request  start/mode/src_addr/dst_addr/len/fill_val (sampled in IDLE)
//                status   busy (RD/WR states), done (one-cycle pulse)
//                memory   mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata in
// COPY spends RD+WR per byte; FILL spends WR only. len==0 or COPY onto itself
// goes straight to DONE without touching memory.
// -----------------------------------------------------------------------------
module dmem_dma
  import dmem_dma_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input logic        clk,
  input logic        rst_n,
  dmem_dma_if.master bus
);

  state_t        r_state;
  mode_t         r_mode;
  logic [DW-1:0] r_fill;

  logic          w_accept;
  logic          w_noop;
  logic          w_req_copy;
  logic          w_step;
  logic          w_last;
  logic [AW-1:0] w_src_addr;
  logic [AW-1:0] w_dst_addr;

  assign w_req_copy = (mode_t'(bus.mode) == COPY);
  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_noop     = (bus.len == '0) || (w_req_copy && (bus.src_addr == bus.dst_addr));
  assign w_step     = (r_state == WR);

  dmem_dma_addr_gen #(.AW(AW)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_copy     (w_req_copy),
    .i_src      (bus.src_addr),
    .i_dst      (bus.dst_addr),
    .i_len      (bus.len),
    .o_src_addr (w_src_addr),
    .o_dst_addr (w_dst_addr),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= COPY;
      r_fill  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode <= mode_t'(bus.mode);
            r_fill <= bus.fill_val;
            if (w_noop)                        r_state <= DONE;
            else if (mode_t'(bus.mode) == FILL) r_state <= WR;
            else                               r_state <= RD;
          end
        end
        RD:      r_state <= WR;
        WR: begin
          if (w_last)               r_state <= DONE;
          else if (r_mode == COPY)  r_state <= RD;
          else                      r_state <= WR;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so an async reset clears
  // them immediately. In WR of a COPY the write data is the memory's registered
  // read result from the preceding RD cycle, passed through unregistered.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      RD: begin
        bus.busy     = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_addr = w_src_addr;
      end
      WR: begin
        bus.busy      = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = w_dst_addr;
        bus.mem_wdata = (r_mode == FILL) ? r_fill : bus.mem_rdata;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_dma.sv
// -----------------------------------------------------------------------------
// tb_dmem_dma
// Directed bench for dmem_dma with a 256x8 registered-read memory behind the
// port. The bench can preload memory through a side write port while the DMA
// is idle. A negedge monitor tallies busy/done cycles and logs strobe addresses.
// -----------------------------------------------------------------------------
module tb_dmem_dma;
  import dmem_dma_pkg::*;

  logic clk;
  logic rst_n;

  dmem_dma_if #(.AW(8), .DW(8)) dif ();

  dmem_dma #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_wdata;

  always @(posedge clk) begin
    if (dif.mem_write)  mem[dif.mem_addr] <= dif.mem_wdata;
    else if (tb_we)     mem[tb_addr]      <= tb_wdata;
    if (dif.mem_read)   dif.mem_rdata     <= mem[dif.mem_addr];
  end

  // ---------------- monitor ----------------
  int         busy_cnt, done_cnt, rd_cnt, wr_cnt, both_cnt, idle_bad;
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];

  initial begin
    busy_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0; idle_bad = 0;
  end

  always @(negedge clk) begin
    if (dif.busy) busy_cnt++;
    if (dif.done) done_cnt++;
    if (dif.mem_read) begin
      rd_cnt++;
      rd_q.push_back(dif.mem_addr);
    end
    if (dif.mem_write) begin
      wr_cnt++;
      wr_q.push_back(dif.mem_addr);
    end
    if (dif.mem_read && dif.mem_write) both_cnt++;
    if (!dif.busy && (dif.mem_read || dif.mem_write ||
                      dif.mem_addr != 8'h00 || dif.mem_wdata != 8'h00)) idle_bad++;
  end

  // ---------------- checking helpers ----------------
  int n_checks;
  int n_errors;
  int b0, d0, r0, w0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b0 = busy_cnt; d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic drive_req(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f);
    dif.mode = m; dif.src_addr = s; dif.dst_addr = d; dif.len = l; dif.fill_val = f;
  endtask

  // Waits (bounded) for done; n = negedges from the accepting edge to done.
  task automatic wait_done(output int n);
    n = 1;
    while (!dif.done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, dif.done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] l, input logic [7:0] f, output int n);
    @(negedge clk);
    drive_req(m, s, d, l, f);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(n);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    tb_we = 1'b0; tb_addr = 8'h00; tb_wdata = 8'h00;
    dif.start = 1'b0;
    drive_req(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",  {31'd0, dif.busy},      32'd0);
    check("rst_done",  {31'd0, dif.done},      32'd0);
    check("rst_rd",    {31'd0, dif.mem_read},  32'd0);
    check("rst_wr",    {31'd0, dif.mem_write}, 32'd0);
    check("rst_addr",  {24'd0, dif.mem_addr},  32'd0);
    check("rst_wdata", {24'd0, dif.mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain ascending COPY 0x10 -> 0x40, 4 bytes
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    snap();
    xfer(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, cyc);
    check("cp_m40",   {24'd0, mem[8'h40]}, 32'hA1);
    check("cp_m41",   {24'd0, mem[8'h41]}, 32'hB2);
    check("cp_m42",   {24'd0, mem[8'h42]}, 32'hC3);
    check("cp_m43",   {24'd0, mem[8'h43]}, 32'hD4);
    check("cp_busy",  busy_cnt - b0, 32'd8);
    check("cp_done",  done_cnt - d0, 32'd1);
    check("cp_cyc",   cyc, 32'd9);
    check("cp_rd0",   {24'd0, rd_q[r0]}, 32'h10);
    check("cp_wr0",   {24'd0, wr_q[w0]}, 32'h40);
    check("cp_nrd",   rd_cnt - r0, 32'd4);

    // Overlapping COPY 0x10 -> 0x12: must run descending
    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
    snap();
    xfer(1'b0, 8'h10, 8'h12, 8'd4, 8'h00, cyc);
    check("ov_m12",  {24'd0, mem[8'h12]}, 32'h01);
    check("ov_m13",  {24'd0, mem[8'h13]}, 32'h02);
    check("ov_m14",  {24'd0, mem[8'h14]}, 32'h03);
    check("ov_m15",  {24'd0, mem[8'h15]}, 32'h04);
    check("ov_rd0",  {24'd0, rd_q[r0]},     32'h13);
    check("ov_wr0",  {24'd0, wr_q[w0]},     32'h15);
    check("ov_wr3",  {24'd0, wr_q[w0 + 3]}, 32'h12);

    // Source window wrapping 0xFF -> 0x00
    poke(8'hFE, 8'h05); poke(8'hFF, 8'h06); poke(8'h00, 8'h07); poke(8'h01, 8'h08);
    snap();
    xfer(1'b0, 8'hFE, 8'h20, 8'd4, 8'h00, cyc);
    check("wr_rd0", {24'd0, rd_q[r0]},     32'hFE);
    check("wr_rd1", {24'd0, rd_q[r0 + 1]}, 32'hFF);
    check("wr_rd2", {24'd0, rd_q[r0 + 2]}, 32'h00);
    check("wr_rd3", {24'd0, rd_q[r0 + 3]}, 32'h01);
    check("wr_m20", {24'd0, mem[8'h20]}, 32'h05);
    check("wr_m23", {24'd0, mem[8'h23]}, 32'h08);

    // FILL across the wrap point
    snap();
    xfer(1'b1, 8'h00, 8'hFF, 8'd2, 8'h5A, cyc);
    check("fl_wa0",  {24'd0, wr_q[w0]},     32'hFF);
    check("fl_wa1",  {24'd0, wr_q[w0 + 1]}, 32'h00);
    check("fl_mFF",  {24'd0, mem[8'hFF]}, 32'h5A);
    check("fl_m00",  {24'd0, mem[8'h00]}, 32'h5A);
    check("fl_busy", busy_cnt - b0, 32'd2);
    check("fl_nrd",  rd_cnt - r0, 32'd0);
    check("fl_cyc",  cyc, 32'd3);

    // len = 0 no-op
    snap();
    xfer(1'b0, 8'h01, 8'h02, 8'd0, 8'h00, cyc);
    check("z_cyc",  cyc, 32'd1);
    check("z_acc",  (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
    check("z_busy", busy_cnt - b0, 32'd0);
    check("z_done", done_cnt - d0, 32'd1);

    // COPY onto itself is a no-op too
    snap();
    xfer(1'b0, 8'h33, 8'h33, 8'd5, 8'h00, cyc);
    check("s_cyc",  cyc, 32'd1);
    check("s_acc",  (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
    check("s_done", done_cnt - d0, 32'd1);

    // start held again while busy must be ignored
    poke(8'h30, 8'h11); poke(8'h31, 8'h22); poke(8'h32, 8'h33);
    poke(8'h50, 8'h00); poke(8'h51, 8'h00); poke(8'h52, 8'h00); poke(8'h90, 8'hEE);
    snap();
    @(negedge clk);
    drive_req(1'b0, 8'h30, 8'h50, 8'd3, 8'h00);
    dif.start = 1'b1;
    @(negedge clk);
    drive_req(1'b1, 8'h30, 8'h90, 8'd1, 8'h99);
    repeat (3) @(negedge clk);
    dif.start = 1'b0;
    cyc = 4;
    while (!dif.done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("ig_cyc", cyc, 32'd7);
    repeat (5) @(negedge clk);
    check("ig_m50",  {24'd0, mem[8'h50]}, 32'h11);
    check("ig_m52",  {24'd0, mem[8'h52]}, 32'h33);
    check("ig_m90",  {24'd0, mem[8'h90]}, 32'hEE);
    check("ig_done", done_cnt - d0, 32'd1);
    check("ig_busy", busy_cnt - b0, 32'd6);

    // Async reset in the middle of a 6-byte COPY, right after the 2nd write
    for (int i = 0; i < 6; i++) begin
      poke(8'h60 + 8'(i), 8'hC0 + 8'(i));
      poke(8'hA0 + 8'(i), 8'h00);
    end
    snap();
    @(negedge clk);
    drive_req(1'b0, 8'h60, 8'hA0, 8'd6, 8'h00);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    cyc = 0;
    #1;
    while ((wr_cnt - w0) < 2 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("rs_two_wr", wr_cnt - w0, 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_busy", {31'd0, dif.busy},     32'd0);
    check("rs_rd",   {31'd0, dif.mem_read}, 32'd0);
    check("rs_addr", {24'd0, dif.mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rs_mA0",  {24'd0, mem[8'hA0]}, 32'hC0);
    check("rs_mA1",  {24'd0, mem[8'hA1]}, 32'hC1);
    check("rs_mA2",  {24'd0, mem[8'hA2]}, 32'h00);
    check("rs_done", done_cnt - d0, 32'd0);

    // Normal operation after the aborted transfer
    snap();
    xfer(1'b1, 8'h00, 8'hA2, 8'd2, 8'h77, cyc);
    check("pr_mA2", {24'd0, mem[8'hA2]}, 32'h77);
    check("pr_mA3", {24'd0, mem[8'hA3]}, 32'h77);
    check("pr_mA4", {24'd0, mem[8'hA4]}, 32'h00);
    check("pr_cyc", cyc, 32'd3);

    // Global port invariants
    @(negedge clk);
    check("inv_both", both_cnt, 32'd0);
    check("inv_idle", idle_bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
